// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction memory combinationally
// and buffers {instr, pc} pairs in a 2-entry queue toward decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    logic [31:0] pc_r;
    logic [31:0] instr_q_r [2];
    logic [31:0] pc_q_r    [2];
    logic        rd_ptr_r;
    logic        wr_ptr_r;
    logic [1:0]  count_r;
    logic        push_s;
    logic        pop_s;
    logic [1:0]  count_next_s;

    // Handshake decode: a redirect suppresses both queue operations.
    always_comb begin
        pop_s  = 1'b0;
        push_s = 1'b0;
        if (redirect_valid) begin
            pop_s  = 1'b0;
            push_s = 1'b0;
        end else begin
            pop_s  = if_valid & if_ready;
            push_s = (count_r != 2'd2) | pop_s;
        end
    end

    // Occupancy update; simultaneous push and pop cancel out.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
    end

    // PC, pointers, occupancy and queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= {RESET_PC[31:2], 2'b00};
            rd_ptr_r     <= 1'b0;
            wr_ptr_r     <= 1'b0;
            count_r      <= 2'd0;
            instr_q_r[0] <= 32'h0000_0000;
            instr_q_r[1] <= 32'h0000_0000;
            pc_q_r[0]    <= 32'h0000_0000;
            pc_q_r[1]    <= 32'h0000_0000;
        end else if (redirect_valid) begin
            pc_r     <= {redirect_pc[31:2], 2'b00};
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                instr_q_r[wr_ptr_r] <= imem_instr;
                pc_q_r[wr_ptr_r]    <= pc_r;
                wr_ptr_r            <= ~wr_ptr_r;
                pc_r                <= pc_r + 32'd4;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_next_s;
        end
    end

    // Outputs are taken straight from registered state.
    always_comb begin
        imem_addr   = {pc_r[31:2], 2'b00};
        if_valid    = (count_r != 2'd0);
        if_instr    = instr_q_r[rd_ptr_r];
        if_pc       = pc_q_r[rd_ptr_r];
        if_pc_plus4 = pc_q_r[rd_ptr_r] + 32'd4;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: stream, back-pressure, redirect, wrap and async reset.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int vectors;
    int miscompares;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    // Combinational instruction memory model.
    always_comb begin
        imem_instr = mem_word(imem_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, ".pc"}, if_pc, pc);
        check({tag, ".instr"}, if_instr, mem_word(pc));
        check({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic check_empty(input string tag, input logic [31:0] addr);
        check({tag, ".valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0000_0000;
        if_ready       = 1'b1;

        // Reset state
        #12;
        check_empty("rst", 32'h0000_0000);
        check("rst.instr", if_instr, 32'h0000_0000);
        check("rst.pc", if_pc, 32'h0000_0000);
        check("rst.pc4", if_pc_plus4, 32'h0000_0004);
        rst_n = 1'b1;

        // Streaming at full rate
        tick(); check_head("s0", 32'h0000_0000, 32'h0000_0004);
        tick(); check_head("s1", 32'h0000_0004, 32'h0000_0008);
        tick(); check_head("s2", 32'h0000_0008, 32'h0000_000C);

        // Redirect together with an accept: nothing popped, queue empty
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0000;
        tick(); check_empty("rda", 32'h0000_0000);
        redirect_valid = 1'b0;
        if_ready       = 1'b0;

        // Back-pressure: fill two entries, then the PC freezes at 8
        tick(); check_head("bp0", 32'h0000_0000, 32'h0000_0004);
        tick(); check_head("bp1", 32'h0000_0000, 32'h0000_0008);
        tick(); check_head("bp2", 32'h0000_0000, 32'h0000_0008);
        tick(); check_head("bp3", 32'h0000_0000, 32'h0000_0008);
        tick(); check_head("bp4", 32'h0000_0000, 32'h0000_0008);
        tick(); check_head("bp5", 32'h0000_0000, 32'h0000_0008);
        if_ready = 1'b1;
        tick(); check_head("rel0", 32'h0000_0004, 32'h0000_000C);
        tick(); check_head("rel1", 32'h0000_0008, 32'h0000_0010);
        tick(); check_head("rel2", 32'h0000_000C, 32'h0000_0014);

        // Redirect with a full queue, low address bits dropped
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        if_ready       = 1'b0;
        tick(); check_empty("rdf", 32'h0000_0100);
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        tick(); check_head("rdt", 32'h0000_0100, 32'h0000_0104);

        // PC wrap-around
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(); check_empty("wr0", 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        tick(); check_head("wr1", 32'hFFFF_FFFC, 32'h0000_0000);
        check("wr1.pc4zero", if_pc_plus4, 32'h0000_0000);
        tick(); check_head("wr2", 32'h0000_0000, 32'h0000_0004);

        // Two entries queued, then asynchronous reset between edges
        if_ready = 1'b0;
        tick(); check_head("ar0", 32'h0000_0000, 32'h0000_0008);
        #2 rst_n = 1'b0;
        #1;
        check_empty("ar1", 32'h0000_0000);
        check("ar1.pc", if_pc, 32'h0000_0000);
        check("ar1.instr", if_instr, 32'h0000_0000);
        #2 rst_n = 1'b1;
        if_ready = 1'b1;
        tick(); check_head("ar2", 32'h0000_0000, 32'h0000_0004);
        tick(); check_head("ar3", 32'h0000_0004, 32'h0000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
